// File: rtl/mem_byte_access_pkg.sv
// Shared op codes, FSM states and decode helpers for the MEM-stage byte-serial load/store unit.
package mem_byte_access_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP = 8'h20;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'h80;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'h81;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'h82;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'h84;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'h85;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'h88;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'h89;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'h8A;

  typedef enum logic [1:0] {
    MEM_ST_IDLE  = 2'd0,
    MEM_ST_ISSUE = 2'd1,
    MEM_ST_DRAIN = 2'd2,
    MEM_ST_DONE  = 2'd3
  } mem_st_e;

  // last_idx is the index of the final byte: 0 for B, 1 for H, 3 for W.
  typedef struct packed {
    logic       is_mem;
    logic       is_store;
    logic       sext;
    logic [1:0] last_idx;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [ALUOP_W-1:0] op);
    mem_op_t d;
    d = '0;
    case (op)
      EXE_LB_OP:  d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b1, last_idx: 2'd0};
      EXE_LH_OP:  d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b1, last_idx: 2'd1};
      EXE_LW_OP:  d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b0, last_idx: 2'd3};
      EXE_LBU_OP: d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b0, last_idx: 2'd0};
      EXE_LHU_OP: d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b0, last_idx: 2'd1};
      EXE_SB_OP:  d = '{is_mem: 1'b1, is_store: 1'b1, sext: 1'b0, last_idx: 2'd0};
      EXE_SH_OP:  d = '{is_mem: 1'b1, is_store: 1'b1, sext: 1'b0, last_idx: 2'd1};
      EXE_SW_OP:  d = '{is_mem: 1'b1, is_store: 1'b1, sext: 1'b0, last_idx: 2'd3};
      default:    d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [REG_W-1:0] extend_load(input logic [REG_W-1:0] raw, input mem_op_t op);
    case (op.last_idx)
      2'd0:    return op.sext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      2'd1:    return op.sext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
    return ((op.last_idx == 2'd1) && a[0]) || ((op.last_idx == 2'd3) && (a != 2'd0));
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return delay line: carries {valid, byte index} of each accepted read for RD_LAT cycles.
module mem_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld,
  input  logic [1:0] push_idx,
  output logic       pop_vld,
  output logic [1:0] pop_idx
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [1:0]        idx_q [RD_LAT];
  logic [1:0]        idx_d [RD_LAT];

  always_comb begin
    vld_d[0] = push_vld;
    idx_d[0] = push_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // Index payload is meaningless without its valid bit, so it is not reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  assign pop_vld = vld_q[RD_LAT-1];
  assign pop_idx = idx_q[RD_LAT-1];

endmodule

// File: rtl/mem_byte_access.sv
// MEM stage: byte-serial little-endian loads/stores over a shared byte RAM port, stalling the pipe.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned H/W accesses with mem_err instead of RAM traffic.
module mem_byte_access
  import mem_byte_access_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_in,
  input  logic [REG_ADDR_W-1:0] wd_in,
  input  logic                  wreg_in,
  input  logic [REG_W-1:0]      wdata_in,
  input  logic [REG_W-1:0]      mem_addr_in,
  input  logic [REG_W-1:0]      reg2_in,
  input  logic                  mem_gnt,
  input  logic [7:0]            mem_din,
  output logic [REG_ADDR_W-1:0] wd_out,
  output logic                  wreg_out,
  output logic [REG_W-1:0]      wdata_out,
  output logic                  stallreq,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_err
);

  mem_st_e           state_q, state_d;
  logic [1:0]        issue_idx_q, issue_idx_d;
  logic [REG_W-1:0]  buf_q, buf_d;
  mem_op_t           op;
  logic [ADDR_W-1:0] base;
  logic              misaligned;
  logic              accept;
  logic              pop_vld;
  logic [1:0]        pop_idx;
  logic              unused_addr_bits;

  assign op               = decode_op(aluop_in);
  assign base             = mem_addr_in[ADDR_W-1:0];
  assign unused_addr_bits = ^mem_addr_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = op.is_mem && is_misaligned(op, mem_addr_in[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .push_vld (accept && !op.is_store),
    .push_idx (issue_idx_q),
    .pop_vld  (pop_vld),
    .pop_idx  (pop_idx)
  );

  always_comb begin
    buf_d = buf_q;
    if (pop_vld) buf_d[8*pop_idx +: 8] = mem_din;
  end

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    accept      = 1'b0;
    wd_out      = '0;
    wreg_out    = 1'b0;
    wdata_out   = '0;
    stallreq    = 1'b0;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_a       = '0;
    mem_dout    = '0;
    mem_err     = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        if (misaligned) begin
          mem_err = 1'b1;
          wd_out  = wd_in;
        end else if (op.is_mem) begin
          stallreq = 1'b1;
          mem_req  = 1'b1;
          state_d  = MEM_ST_ISSUE;
        end else begin
          wd_out    = wd_in;
          wreg_out  = wreg_in;
          wdata_out = wdata_in;
        end
      end
      MEM_ST_ISSUE: begin
        stallreq = 1'b1;
        mem_req  = 1'b1;
      end
      MEM_ST_DRAIN: begin
        stallreq = 1'b1;
        if (pop_vld && (pop_idx == op.last_idx)) state_d = MEM_ST_DONE;
      end
      MEM_ST_DONE: begin
        wd_out    = wd_in;
        wreg_out  = op.is_store ? 1'b0 : wreg_in;
        wdata_out = op.is_store ? wdata_in : extend_load(buf_q, op);
        state_d   = MEM_ST_IDLE;
      end
      default: state_d = MEM_ST_IDLE;
    endcase

    // Shared issue path: byte 0 may already go out from IDLE in the op's first cycle.
    if (mem_req) begin
      mem_wr = op.is_store;
      mem_a  = base + ADDR_W'(issue_idx_q);
      if (op.is_store) mem_dout = reg2_in[8*issue_idx_q +: 8];
      accept = mem_gnt;
      if (accept) begin
        if (issue_idx_q == op.last_idx) begin
          issue_idx_d = 2'd0;
          state_d     = op.is_store ? MEM_ST_DONE : MEM_ST_DRAIN;
        end else begin
          issue_idx_d = issue_idx_q + 2'd1;
        end
      end
    end

    if (rst) begin
      wd_out    = '0;
      wreg_out  = 1'b0;
      wdata_out = '0;
      stallreq  = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_a     = '0;
      mem_dout  = '0;
      mem_err   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_ST_IDLE;
      issue_idx_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule
